// File: rtl/rst_seq_if.sv
// rst_seq_if: signal bundle between the reset sequencer and its environment.
//   lock_in    : PLL/PS lock (asynchronous to the sequencer clock)
//   sw_rst_req : per-channel soft reset request, level
//   rstn_out   : per-channel active-low resets
//   rst_done   : all channels out of reset
//   state_out  : sequencer FSM state
// slave = sequencer side, master = environment side.
interface rst_seq_if #(
  parameter int CH_NUM = 4
);
  logic              lock_in;
  logic [CH_NUM-1:0] sw_rst_req;
  logic [CH_NUM-1:0] rstn_out;
  logic              rst_done;
  logic [1:0]        state_out;

  modport master (output lock_in, sw_rst_req, input rstn_out, rst_done, state_out);
  modport slave  (input lock_in, sw_rst_req, output rstn_out, rst_done, state_out);
endinterface

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: multi-channel reset sequencer.
//   Holds all channel resets for HOLD_CYC cycles, waits for synchronised lock,
//   then releases channels in index order STAGE_CYC cycles apart. In S_RUN each
//   channel can be pulsed low for HOLD_CYC cycles by sw_rst_req. Loss of lock
//   in S_REL/S_RUN restarts the whole sequence.
// Ports:
//   clk_in : clock
//   rst_in : synchronous reset, active-high
//   bus    : rst_seq_if slave (lock_in, sw_rst_req in; rstn_out, rst_done,
//            state_out out, all outputs registered)
module rst_seq_gen #(
  parameter int CH_NUM    = 4,
  parameter int HOLD_CYC  = 16,
  parameter int STAGE_CYC = 8,
  parameter int SYNC_STG  = 2,
  parameter int CNT_W     = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  rst_seq_if.slave     bus
);
  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {S_HOLD = 2'd0, S_LOCK = 2'd1, S_REL = 2'd2, S_RUN = 2'd3} state_e;

  state_e                        state_q, state_d;
  logic [SYNC_STG-1:0]           sync_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CH_NUM-1:0][CNT_W-1:0]  swcnt_q, swcnt_d;
  logic [CH_NUM-1:0]             rstn_q, rstn_d;
  logic                          done_q, done_d;

  logic lock_sync, hold_end, stage_end, last_ch, lost;

  assign lock_sync = sync_q[SYNC_STG-1];
  assign hold_end  = (cnt_q == CNT_W'(HOLD_CYC - 1));
  assign stage_end = (cnt_q == CNT_W'(STAGE_CYC - 1));
  assign last_ch   = (idx_q == IDX_W'(CH_NUM - 1));
  assign lost      = ((state_q == S_REL) || (state_q == S_RUN)) && !lock_sync;

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_HOLD;
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      swcnt_q <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STG-2:0], bus.lock_in};
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      swcnt_q <= swcnt_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: if (hold_end) state_d = S_LOCK;
      S_LOCK: if (lock_sync) state_d = S_REL;
      S_REL: begin
        if (lost)                       state_d = S_HOLD;
        else if (stage_end && last_ch)  state_d = S_RUN;
      end
      S_RUN:  if (lost) state_d = S_HOLD;
      default: state_d = S_HOLD;
    endcase
  end

  // Counters and output next values
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    swcnt_d = swcnt_q;
    rstn_d  = rstn_q;
    case (state_q)
      S_HOLD: begin
        cnt_d  = hold_end ? '0 : cnt_q + CNT_W'(1);
        rstn_d = '0;
      end
      S_LOCK: begin
        cnt_d  = '0;
        idx_d  = '0;
        rstn_d = '0;
      end
      S_REL: begin
        if (lost) begin
          cnt_d   = '0;
          idx_d   = '0;
          swcnt_d = '0;
          rstn_d  = '0;
        end else if (stage_end) begin
          rstn_d[idx_q] = 1'b1;
          idx_d         = last_ch ? '0 : idx_q + IDX_W'(1);
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (lost) begin
          cnt_d   = '0;
          idx_d   = '0;
          swcnt_d = '0;
          rstn_d  = '0;
        end else begin
          // swcnt loads HOLD_CYC on a request; the channel rises on the edge
          // that sees swcnt==1, i.e. HOLD_CYC edges after the last request.
          for (int i = 0; i < CH_NUM; i++) begin
            if (bus.sw_rst_req[i])     swcnt_d[i] = CNT_W'(HOLD_CYC);
            else if (swcnt_q[i] != '0) swcnt_d[i] = swcnt_q[i] - CNT_W'(1);
            rstn_d[i] = !(bus.sw_rst_req[i] || (swcnt_q[i] > CNT_W'(1)));
          end
        end
      end
      default: begin
        cnt_d  = '0;
        rstn_d = '0;
      end
    endcase
    done_d = (state_d == S_RUN) && (&rstn_d);
  end

  assign bus.rstn_out  = rstn_q;
  assign bus.rst_done  = done_q;
  assign bus.state_out = state_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// tb_rst_seq_gen: bench for rst_seq_gen (CH_NUM=4, HOLD_CYC=16, STAGE_CYC=8,
// SYNC_STG=2). Edge numbers count posedges from the first edge with rst_in=0.
// Expectations are pushed to a scoreboard queue keyed by edge number and
// compared 1 time unit after that edge.
module tb_rst_seq_gen;
  localparam int CH = 4;

  typedef struct {
    int             ed;
    logic [CH-1:0]  req;
    logic [CH-1:0]  rstn;
    logic           done;
    logic [1:0]     st;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  rst_seq_if #(.CH_NUM(CH)) bus ();

  rst_seq_gen #(
    .CH_NUM(CH), .HOLD_CYC(16), .STAGE_CYC(8), .SYNC_STG(2), .CNT_W(16)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  vec_t sbq[$];
  vec_t t1[$];
  vec_t t4[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   edge_n = 0;

  function automatic vec_t v(int ed, logic [CH-1:0] req, logic [CH-1:0] rstn,
                             logic done, logic [1:0] st);
    vec_t r;
    r.ed = ed; r.req = req; r.rstn = rstn; r.done = done; r.st = st;
    return r;
  endfunction

  task automatic cmp(string nm, int ed, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, ed, act, exp);
    end
  endtask

  task automatic push(int ed, logic [CH-1:0] rstn, logic done, logic [1:0] st);
    sbq.push_back(v(ed, '0, rstn, done, st));
  endtask

  // One clock edge; pops and checks every expectation due at this edge.
  task automatic tick();
    vec_t e;
    @(posedge clk_in);
    #1;
    edge_n++;
    while (sbq.size() != 0 && sbq[0].ed <= edge_n) begin
      e = sbq.pop_front();
      cmp("rstn_out",  edge_n, 8'(bus.rstn_out),  8'(e.rstn));
      cmp("rst_done",  edge_n, 8'(bus.rst_done),  8'(e.done));
      cmp("state_out", edge_n, 8'(bus.state_out), 8'(e.st));
    end
  endtask

  task automatic run_to(int ed);
    while (edge_n < ed) tick();
  endtask

  // Each vector: req is sampled at edge ed and outputs are checked at ed.
  task automatic apply_tbl(input vec_t t[$]);
    foreach (t[i]) begin
      run_to(t[i].ed - 1);
      bus.sw_rst_req = t[i].req;
      sbq.push_back(t[i]);
      tick();
      bus.sw_rst_req = '0;
    end
  endtask

  task automatic do_reset(int n);
    rst_in = 1'b1;
    repeat (n) tick();
    rst_in = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    // Power-up sequence with lock held high
    t1.push_back(v(15, 4'h0, 4'h0, 1'b0, 2'd0));
    t1.push_back(v(16, 4'h0, 4'h0, 1'b0, 2'd1));
    t1.push_back(v(17, 4'h0, 4'h0, 1'b0, 2'd2));
    t1.push_back(v(24, 4'h0, 4'h0, 1'b0, 2'd2));
    t1.push_back(v(25, 4'h0, 4'h1, 1'b0, 2'd2));
    t1.push_back(v(32, 4'h0, 4'h1, 1'b0, 2'd2));
    t1.push_back(v(33, 4'h0, 4'h3, 1'b0, 2'd2));
    t1.push_back(v(41, 4'h0, 4'h7, 1'b0, 2'd2));
    t1.push_back(v(48, 4'h0, 4'h7, 1'b0, 2'd2));
    t1.push_back(v(49, 4'h0, 4'hF, 1'b1, 2'd3));
    t1.push_back(v(60, 4'h0, 4'hF, 1'b1, 2'd3));
    // Soft resets in S_RUN: single pulse, re-trigger, two overlapping channels
    t4.push_back(v(61,  4'h4, 4'hB, 1'b0, 2'd3));
    t4.push_back(v(76,  4'h0, 4'hB, 1'b0, 2'd3));
    t4.push_back(v(77,  4'h0, 4'hF, 1'b1, 2'd3));
    t4.push_back(v(81,  4'h4, 4'hB, 1'b0, 2'd3));
    t4.push_back(v(91,  4'h4, 4'hB, 1'b0, 2'd3));
    t4.push_back(v(97,  4'h0, 4'hB, 1'b0, 2'd3));
    t4.push_back(v(106, 4'h0, 4'hB, 1'b0, 2'd3));
    t4.push_back(v(107, 4'h0, 4'hF, 1'b1, 2'd3));
    t4.push_back(v(110, 4'h1, 4'hE, 1'b0, 2'd3));
    t4.push_back(v(115, 4'h8, 4'h6, 1'b0, 2'd3));
    t4.push_back(v(126, 4'h0, 4'h7, 1'b0, 2'd3));
    t4.push_back(v(130, 4'h0, 4'h7, 1'b0, 2'd3));
    t4.push_back(v(131, 4'h0, 4'hF, 1'b1, 2'd3));

    bus.lock_in    = 1'b1;
    bus.sw_rst_req = '0;

    // Reset state
    do_reset(5);
    cmp("rst_rstn",  0, 8'(bus.rstn_out),  8'h00);
    cmp("rst_done",  0, 8'(bus.rst_done),  8'h00);
    cmp("rst_state", 0, 8'(bus.state_out), 8'h00);

    apply_tbl(t1);
    apply_tbl(t4);

    // Lock loss in S_RUN: lock_in first sampled 0 at edge 136
    run_to(135);
    bus.lock_in = 1'b0;
    push(137, 4'hF, 1'b1, 2'd3);
    push(138, 4'h0, 1'b0, 2'd0);
    run_to(140);
    bus.lock_in = 1'b1;
    push(153, 4'h0, 1'b0, 2'd0);
    push(154, 4'h0, 1'b0, 2'd1);
    push(155, 4'h0, 1'b0, 2'd2);
    push(163, 4'h1, 1'b0, 2'd2);
    push(187, 4'hF, 1'b1, 2'd3);
    run_to(187);

    // Lock loss and sw_rst_req=1111 seen on the same edge (193)
    run_to(190);
    bus.lock_in = 1'b0;
    push(192, 4'hF, 1'b1, 2'd3);
    push(193, 4'h0, 1'b0, 2'd0);
    run_to(192);
    bus.sw_rst_req = 4'hF;
    tick();
    bus.sw_rst_req = '0;
    bus.lock_in    = 1'b1;
    push(209, 4'h0, 1'b0, 2'd1);
    push(210, 4'h0, 1'b0, 2'd2);
    push(218, 4'h1, 1'b0, 2'd2);
    push(242, 4'hF, 1'b1, 2'd3);
    push(250, 4'hF, 1'b1, 2'd3);
    run_to(250);

    // Late lock: lock_in first sampled 1 at edge 40
    bus.lock_in = 1'b0;
    do_reset(5);
    push(16, 4'h0, 1'b0, 2'd1);
    push(39, 4'h0, 1'b0, 2'd1);
    push(41, 4'h0, 1'b0, 2'd1);
    push(42, 4'h0, 1'b0, 2'd2);
    push(49, 4'h0, 1'b0, 2'd2);
    push(50, 4'h1, 1'b0, 2'd2);
    push(58, 4'h3, 1'b0, 2'd2);
    push(60, 4'h3, 1'b0, 2'd2);
    run_to(39);
    bus.lock_in = 1'b1;
    run_to(60);

    // One-cycle rst_in in S_REL with two channels out, then full restart
    rst_in = 1'b1;
    push(61, 4'h0, 1'b0, 2'd0);
    tick();
    rst_in = 1'b0;
    edge_n = 0;
    apply_tbl(t1);

    cmp("sb_empty", edge_n, 8'(sbq.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
